// File: rtl/mem_arb_pkg.sv
// Shared widths, master IDs, FSM encoding and transfer payload for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned PORT_ADDR_WIDTH = 32;
  localparam int unsigned PORT_DATA_WIDTH = 32;
  localparam int unsigned NUM_MASTERS     = 3;
  localparam int unsigned ID_WIDTH        = 2;

  typedef logic [ID_WIDTH-1:0] mst_id_t;

  // Master IDs: ex data port, ifu fetch, debug
  localparam mst_id_t MST_EX  = mst_id_t'(0);
  localparam mst_id_t MST_IFU = mst_id_t'(1);
  localparam mst_id_t MST_DBG = mst_id_t'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Fields latched from the winning master at arbitration
  typedef struct packed {
    logic [PORT_ADDR_WIDTH-1:0] addr;
    logic                       we;
    logic [PORT_DATA_WIDTH-1:0] wdata;
  } xfer_t;

endpackage

// File: rtl/mem_arb_if.sv
// Master-side and slave-side bus of the memory arbiter.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic                       m0_req_i, m1_req_i, m2_req_i;
  logic [PORT_ADDR_WIDTH-1:0] m0_addr_i, m1_addr_i, m2_addr_i;
  logic                       m0_we_i, m1_we_i, m2_we_i;
  logic [PORT_DATA_WIDTH-1:0] m0_wdata_i, m1_wdata_i, m2_wdata_i;
  logic                       m0_gnt_o, m1_gnt_o, m2_gnt_o;
  logic                       m0_rvalid_o, m1_rvalid_o, m2_rvalid_o;
  logic [PORT_DATA_WIDTH-1:0] m0_rdata_o, m1_rdata_o, m2_rdata_o;

  logic                       s_req_o;
  logic [PORT_ADDR_WIDTH-1:0] s_addr_o;
  logic                       s_we_o;
  logic [PORT_DATA_WIDTH-1:0] s_wdata_o;
  logic [PORT_DATA_WIDTH-1:0] s_rdata_i;
  logic                       s_rvalid_i;

  logic                       hold_flag_o;
  logic                       err_o;

  // Arbiter side
  modport slave (
    input  m0_req_i, m1_req_i, m2_req_i,
    input  m0_addr_i, m1_addr_i, m2_addr_i,
    input  m0_we_i, m1_we_i, m2_we_i,
    input  m0_wdata_i, m1_wdata_i, m2_wdata_i,
    output m0_gnt_o, m1_gnt_o, m2_gnt_o,
    output m0_rvalid_o, m1_rvalid_o, m2_rvalid_o,
    output m0_rdata_o, m1_rdata_o, m2_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_wdata_o,
    input  s_rdata_i, s_rvalid_i,
    output hold_flag_o, err_o
  );

  // Environment side (masters and memory)
  modport master (
    output m0_req_i, m1_req_i, m2_req_i,
    output m0_addr_i, m1_addr_i, m2_addr_i,
    output m0_we_i, m1_we_i, m2_we_i,
    output m0_wdata_i, m1_wdata_i, m2_wdata_i,
    input  m0_gnt_o, m1_gnt_o, m2_gnt_o,
    input  m0_rvalid_o, m1_rvalid_o, m2_rvalid_o,
    input  m0_rdata_o, m1_rdata_o, m2_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_wdata_o,
    output s_rdata_i, s_rvalid_i,
    input  hold_flag_o, err_o
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: fixed priority m0 > m1 > m2 unless m2 is being forced.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   force_m2,
  output mst_id_t                pick_id_c,
  output logic                   pick_valid_c
);

  // Priority encode with starvation override
  always_comb begin
    pick_id_c    = MST_EX;
    pick_valid_c = |req;
    if (force_m2 && req[2]) begin
      pick_id_c = MST_DBG;
    end else if (req[0]) begin
      pick_id_c = MST_EX;
    end else if (req[1]) begin
      pick_id_c = MST_IFU;
    end else if (req[2]) begin
      pick_id_c = MST_DBG;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Three-master memory arbiter, one outstanding transfer, with debug-port anti-starvation
// and a WAIT timeout that aborts a silent slave.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);
  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

  arb_state_t                 state;
  mst_id_t                    owner;
  xfer_t                      xfer;
  logic [STARVE_W-1:0]        starve_cnt;
  logic [TMO_W-1:0]           tmo_cnt;
  logic [NUM_MASTERS-1:0]     gnt_q;
  logic                       s_req_q;

  logic [NUM_MASTERS-1:0]     req_vec;
  logic                       force_m2;
  mst_id_t                    pick_id_c;
  logic                       pick_valid_c;
  xfer_t                      cand;
  logic                       tmo_hit;
  logic                       in_wait;
  logic                       done_c;
  logic                       err_c;
  logic [NUM_MASTERS-1:0]     rvalid_c;
  logic [PORT_DATA_WIDTH-1:0] rdata_c;
  logic                       s_req_c;

  assign req_vec  = {bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
  assign force_m2 = (starve_cnt == STARVE_W'(STARVE_LIM)) && bus.m2_req_i;

  mem_arb_pick u_pick (
    .req          (req_vec),
    .force_m2     (force_m2),
    .pick_id_c    (pick_id_c),
    .pick_valid_c (pick_valid_c)
  );

  // Route the winner's request fields to the latch
  always_comb begin
    cand = '0;
    case (pick_id_c)
      MST_EX:  cand = '{addr: bus.m0_addr_i, we: bus.m0_we_i, wdata: bus.m0_wdata_i};
      MST_IFU: cand = '{addr: bus.m1_addr_i, we: bus.m1_we_i, wdata: bus.m1_wdata_i};
      MST_DBG: cand = '{addr: bus.m2_addr_i, we: bus.m2_we_i, wdata: bus.m2_wdata_i};
      default: cand = '0;
    endcase
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT));

  // Arbitration FSM, starvation and timeout counters, latched transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= MST_EX;
      xfer       <= '0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      gnt_q      <= '0;
      s_req_q    <= 1'b0;
    end else begin
      gnt_q   <= '0;
      s_req_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.m2_req_i || (pick_id_c == MST_DBG)) begin
            starve_cnt <= '0;
          end else if (starve_cnt != STARVE_W'(STARVE_LIM)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
          end
          if (pick_valid_c) begin
            owner   <= pick_id_c;
            xfer    <= cand;
            gnt_q   <= NUM_MASTERS'(1) << pick_id_c;
            s_req_q <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.s_rvalid_i || tmo_hit) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion decode: slave response wins over a coincident timeout; reset masks everything
  assign in_wait     = rst_n && (state == ST_WAIT);
  assign done_c      = in_wait && (bus.s_rvalid_i || tmo_hit);
  assign err_c       = in_wait && !bus.s_rvalid_i && tmo_hit;
  assign rdata_c     = bus.s_rvalid_i ? bus.s_rdata_i : '0;
  assign rvalid_c[0] = done_c && (owner == MST_EX);
  assign rvalid_c[1] = done_c && (owner == MST_IFU);
  assign rvalid_c[2] = done_c && (owner == MST_DBG);

  assign bus.m0_gnt_o    = rst_n && gnt_q[0];
  assign bus.m1_gnt_o    = rst_n && gnt_q[1];
  assign bus.m2_gnt_o    = rst_n && gnt_q[2];
  assign bus.m0_rvalid_o = rvalid_c[0];
  assign bus.m1_rvalid_o = rvalid_c[1];
  assign bus.m2_rvalid_o = rvalid_c[2];
  assign bus.m0_rdata_o  = rvalid_c[0] ? rdata_c : '0;
  assign bus.m1_rdata_o  = rvalid_c[1] ? rdata_c : '0;
  assign bus.m2_rdata_o  = rvalid_c[2] ? rdata_c : '0;

  // Slave request fields are only visible during the issue pulse
  assign s_req_c       = rst_n && s_req_q;
  assign bus.s_req_o   = s_req_c;
  assign bus.s_addr_o  = s_req_c ? xfer.addr : '0;
  assign bus.s_we_o    = s_req_c && xfer.we;
  assign bus.s_wdata_o = s_req_c ? xfer.wdata : '0;

  assign bus.err_o       = err_c;
  assign bus.hold_flag_o = bus.m1_req_i && !rvalid_c[1];

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_LIM, default 8: number of lost arbitrations after which m2 is forced to win.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles before the arbiter aborts the transfer.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 mN_req_i  in  1  master N (N=0..2) request; 0 = ex data port, 1 = ifu fetch, 2 = debug.
REQ-006 mN_addr_i  in  32  master N byte address.
REQ-007 mN_we_i  in  1  master N write enable (1 = write).
REQ-008 mN_wdata_i  in  32  master N write data.
REQ-009 mN_gnt_o  out  1  one-cycle pulse: master N request accepted and issued to slave.
REQ-010 mN_rvalid_o  out  1  one-cycle pulse: master N transfer complete.
REQ-011 mN_rdata_o  out  32  master N read data, valid only with mN_rvalid_o, else 0.
REQ-012 s_req_o  out  1  slave request pulse.
REQ-013 s_addr_o  out  32  slave address.
REQ-014 s_we_o  out  1  slave write enable.
REQ-015 s_wdata_o  out  32  slave write data.
REQ-016 s_rdata_i  in  32  slave read data.
REQ-017 s_rvalid_i  in  1  slave completion (reads and writes).
REQ-018 hold_flag_o  out  1  pc hold request to ctrl while the fetch port is blocked.
REQ-019 err_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT; one transfer outstanding at a time.
REQ-021 IDLE: with any mN_req_i=1, select a winner, latch its ID, addr, we and wdata, go to ISSUE; with none, stay in IDLE.
REQ-022 Priority m0 > m1 > m2, except when starve_cnt == STARVE_LIM and m2_req_i=1; then m2 wins.
REQ-023 starve_cnt increments in each IDLE cycle where m2_req_i=1 and m2 loses, saturating at STARVE_LIM.
REQ-024 starve_cnt clears when m2 is granted or in any IDLE cycle with m2_req_i=0.
REQ-025 ISSUE lasts exactly 1 cycle: s_req_o=1 with the latched fields, the owner's mN_gnt_o=1; then go to WAIT.
REQ-026 s_rvalid_i is ignored in ISSUE and in IDLE.
REQ-027 WAIT on s_rvalid_i=1: owner mN_rvalid_o=1, mN_rdata_o=s_rdata_i (combinational), go to IDLE the next cycle.
REQ-028 WAIT timeout counter starts at 0 on WAIT entry and increments each WAIT cycle without s_rvalid_i.
REQ-029 When the timeout counter reaches TIMEOUT: owner mN_rvalid_o=1, mN_rdata_o=0, err_o=1, go to IDLE.
REQ-030 s_rvalid_i in the same cycle as the timeout is treated as normal completion (err_o=0).
REQ-031 Minimum latency: req at cycle t, gnt at t+1, rvalid at t+2 if the slave responds at t+2; next arbitration at t+3.
REQ-032 Masters hold req, addr, we and wdata stable until their gnt; the arbiter samples them only in IDLE.
REQ-033 Master-side outputs of non-owners are 0; s_addr_o, s_we_o and s_wdata_o are 0 when s_req_o=0.
REQ-034 hold_flag_o = m1_req_i AND NOT m1_rvalid_o (combinational).

Reset
REQ-035 rst_n=0 sampled at a clk edge: FSM to IDLE; starve_cnt, timeout counter, owner ID and latched fields cleared.
REQ-036 During and after reset all outputs are 0 except hold_flag_o, which follows REQ-034.
REQ-037 Reset during ISSUE/WAIT abandons the transfer with no rvalid or err; a late s_rvalid_i is ignored in IDLE.

Structure
REQ-038 Address and data widths come from the shared define file (PORT_ADDR_WIDTH, PORT_DATA_WIDTH).
REQ-039 State encoding and master IDs (0/1/2) live in the shared define file as named constants.
REQ-040 Counter widths are $clog2(param+1).
REQ-041 One sub-module, mem_arb_pick: combinational winner select from the three reqs plus the starve-force flag, outputting a 2-bit ID and a valid.
REQ-042 Target size: 150-300 lines of RTL.

Verification
REQ-043 m0 and m1 request together at t, slave responds 1 cycle after s_req_o -> m0_gnt_o at t+1, m0_rvalid_o at t+2, m1_gnt_o at t+4, hold_flag_o=1 from t to m1_rvalid_o.
REQ-044 m2 requests continuously with m0 re-requesting every IDLE -> m2 granted on its 9th arbitration (STARVE_LIM=8), starve_cnt back to 0.
REQ-045 m0 read of 0x100, slave silent -> after 15 WAIT cycles m0_rvalid_o=1, m0_rdata_o=0, err_o=1, FSM IDLE.
REQ-046 m1 write 0xDEADBEEF to 0x40 -> s_req_o=1, s_we_o=1, s_addr_o=0x40, s_wdata_o=0xDEADBEEF for one cycle; m1_rvalid_o on s_rvalid_i.
REQ-047 rst_n=0 for one cycle in WAIT, then s_rvalid_i=1 -> no mN_rvalid_o, all outputs 0, next request arbitrated normally.
REQ-048 s_rvalid_i=1 in the ISSUE cycle and again on the 3rd WAIT cycle -> completion only on the 3rd WAIT cycle.
